// File: rtl/psw_flag_unit_pkg.sv
// Shared ALU package: condition codes, flag indices, JK helper.
// Imported by the PSW flag unit.
package psw_flag_unit_pkg;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(
    input logic q,
    input logic j,
    input logic k
  );
    logic r;
    r = q;
    unique case (jk_op_e'({j, k}))
      JK_HOLD: r = q;
      JK_CLR:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/psw_flag_unit_stack.sv
// Flag save stack: register array plus occupancy pointer.
// Ports: clk, clr, push, pop, din -> top, level, full, empty.
module psw_save_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [LW-1:0] r_level;

  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_swap;
  logic          w_push;
  logic          w_pop;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_top_idx = AW'(r_level - 1'b1);
  assign w_wr_idx  = r_level[AW-1:0];

  // Push+pop on a non-empty stack rewrites the top in place.
  assign w_swap = push & pop & ~w_empty;
  assign w_push = push & ~w_full & ~w_swap;
  assign w_pop  = pop & ~push & ~w_empty;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_level <= '0;
    end else if (w_push) begin
      r_level <= r_level + 1'b1;
    end else if (w_pop) begin
      r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      if (w_swap) begin
        r_mem[w_top_idx] <= din;
      end else if (w_push) begin
        r_mem[w_wr_idx] <= din;
      end
    end
  end

  assign top   = r_mem[w_top_idx];
  assign level = r_level;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: rtl/psw_flag_unit.sv
// PSW flag register: JK/ALU/bus/stack sources, condition decode.
// Ports: CLK, CLR, J, K, UPD*, ALU_FLAGS, WR_*, PUSH, POP, COND_SEL -> PSW, COND, LEVEL, FULL, EMPTY, OVF, UNF.
module psw_flag_unit
  import psw_flag_unit_pkg::*;
#(
  parameter int NFLAGS    = 4,
  parameter int PSW_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [NFLAGS-1:0]      J,
  input  logic [NFLAGS-1:0]      K,
  input  logic                   UPD,
  input  logic [NFLAGS-1:0]      UPD_MASK,
  input  logic [NFLAGS-1:0]      ALU_FLAGS,
  input  logic                   WR_EN,
  input  logic [NFLAGS-1:0]      WR_DATA,
  input  logic                   PUSH,
  input  logic                   POP,
  input  logic [3:0]             COND_SEL,
  output logic [PSW_WIDTH-1:0]   PSW,
  output logic                   COND,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   OVF,
  output logic                   UNF
);

  logic [NFLAGS-1:0] r_flags;
  logic              r_ovf;
  logic              r_unf;

  logic [NFLAGS-1:0] w_next;
  logic [NFLAGS-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_pop_ok;
  logic              w_ovf_ev;
  logic              w_unf_ev;
  logic              w_n;
  logic              w_z;
  logic              w_v;
  logic              w_c;
  logic              w_cond;
  logic [PSW_WIDTH-1:0] w_psw;

  psw_save_stack #(
    .W     (NFLAGS),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (CLK),
    .clr   (CLR),
    .push  (PUSH),
    .pop   (POP),
    .din   (r_flags),
    .top   (w_top),
    .level (LEVEL),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_pop_ok = POP & ~w_empty;
  assign w_ovf_ev = PUSH & w_full & ~POP;
  assign w_unf_ev = POP & w_empty & ~PUSH;

  // Priority low->high: JK, masked ALU load, bus write, pop.
  always_comb begin
    w_next = r_flags;
    for (int i = 0; i < NFLAGS; i++) begin
      w_next[i] = jk_next(r_flags[i], J[i], K[i]);
      if (UPD && UPD_MASK[i]) begin
        w_next[i] = ALU_FLAGS[i];
      end
    end
    if (WR_EN) begin
      w_next = WR_DATA;
    end
    if (w_pop_ok) begin
      w_next = w_top;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_flags <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_flags <= w_next;
      r_ovf   <= r_ovf | w_ovf_ev;
      r_unf   <= r_unf | w_unf_ev;
    end
  end

  assign w_n = r_flags[FLAG_N];
  assign w_z = r_flags[FLAG_Z];
  assign w_v = r_flags[FLAG_V];
  assign w_c = r_flags[FLAG_C];

  always_comb begin
    w_cond = 1'b0;
    case (COND_SEL)
      CC_EQ:   w_cond = w_z;
      CC_NE:   w_cond = ~w_z;
      CC_CS:   w_cond = w_c;
      CC_CC:   w_cond = ~w_c;
      CC_MI:   w_cond = w_n;
      CC_PL:   w_cond = ~w_n;
      CC_VS:   w_cond = w_v;
      CC_VC:   w_cond = ~w_v;
      CC_HI:   w_cond = w_c & ~w_z;
      CC_LS:   w_cond = ~w_c | w_z;
      CC_GE:   w_cond = (w_n == w_v);
      CC_LT:   w_cond = (w_n != w_v);
      CC_GT:   w_cond = ~w_z & (w_n == w_v);
      CC_LE:   w_cond = w_z | (w_n != w_v);
      CC_AL:   w_cond = 1'b1;
      CC_NV:   w_cond = 1'b0;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_psw = '0;
    w_psw[NFLAGS-1:0] = r_flags;
  end

  assign PSW   = w_psw;
  assign COND  = w_cond;
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;

endmodule

// File: tb/tb_psw_flag_unit.sv
// Scoreboard bench for psw_flag_unit.
// Directed steps queue expectations; a negedge monitor checks them.
module tb_psw_flag_unit;

  logic        CLK;
  logic        CLR;
  logic [3:0]  J;
  logic [3:0]  K;
  logic        UPD;
  logic [3:0]  UPD_MASK;
  logic [3:0]  ALU_FLAGS;
  logic        WR_EN;
  logic [3:0]  WR_DATA;
  logic        PUSH;
  logic        POP;
  logic [3:0]  COND_SEL;
  logic [15:0] PSW;
  logic        COND;
  logic [2:0]  LEVEL;
  logic        FULL;
  logic        EMPTY;
  logic        OVF;
  logic        UNF;

  psw_flag_unit #(
    .NFLAGS    (4),
    .PSW_WIDTH (16),
    .DEPTH     (4)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .J         (J),
    .K         (K),
    .UPD       (UPD),
    .UPD_MASK  (UPD_MASK),
    .ALU_FLAGS (ALU_FLAGS),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .PUSH      (PUSH),
    .POP       (POP),
    .COND_SEL  (COND_SEL),
    .PSW       (PSW),
    .COND      (COND),
    .LEVEL     (LEVEL),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .OVF       (OVF),
    .UNF       (UNF)
  );

  typedef struct packed {
    logic [15:0] psw;
    logic [2:0]  lvl;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
    logic        cond;
  } exp_t;

  exp_t  q_exp[$];
  string q_tag[$];
  exp_t  m_exp;
  exp_t  m_act;
  string m_tag;
  int    n_chk  = 0;
  int    n_fail = 0;
  logic [15:0] tbl;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(negedge CLK) begin
    if (q_exp.size() > 0) begin
      m_exp = q_exp.pop_front();
      m_tag = q_tag.pop_front();
      m_act = {PSW, LEVEL, FULL, EMPTY, OVF, UNF, COND};
      n_chk++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s: got psw=%h lvl=%0d f=%b e=%b o=%b u=%b c=%b want psw=%h lvl=%0d f=%b e=%b o=%b u=%b c=%b",
          m_tag, m_act.psw, m_act.lvl, m_act.full, m_act.empty,
          m_act.ovf, m_act.unf, m_act.cond,
          m_exp.psw, m_exp.lvl, m_exp.full, m_exp.empty,
          m_exp.ovf, m_exp.unf, m_exp.cond);
      end
    end
  end

  function automatic exp_t E(
    input logic [15:0] psw,
    input logic [2:0]  lvl,
    input logic        f,
    input logic        em,
    input logic        ov,
    input logic        un,
    input logic        c
  );
    exp_t e;
    e = {psw, lvl, f, em, ov, un, c};
    return e;
  endfunction

  task automatic idle();
    CLR = 0; J = 0; K = 0;
    UPD = 0; UPD_MASK = 0; ALU_FLAGS = 0;
    WR_EN = 0; WR_DATA = 0;
    PUSH = 0; POP = 0;
    COND_SEL = 4'd14;
  endtask

  task automatic wr(input logic [3:0] d);
    WR_EN = 1; WR_DATA = d;
  endtask

  // Inputs set at negedge+1; edge; expectation queued; back to negedge+1.
  task automatic go(input string tag, input exp_t e);
    @(posedge CLK);
    #1;
    q_exp.push_back(e);
    q_tag.push_back(tag);
    @(negedge CLK);
    #1;
    idle();
  endtask

  task automatic sweep(input string tag, input logic [3:0] f);
    wr(f);
    go({tag, "_load"}, E({12'h0, f}, 0, 0, 1, 0, 0, 1));
    for (int i = 0; i < 16; i++) begin
      COND_SEL = 4'(i);
      go($sformatf("%s_sel%0d", tag, i),
         E({12'h0, f}, 0, 0, 1, 0, 0, tbl[i]));
    end
  endtask

  initial begin
    idle();
    @(negedge CLK);
    #1;

    CLR = 1; J = 4'hF; wr(4'hF);
    go("reset", E(16'h0, 0, 0, 1, 0, 0, 1));

    J = 4'b1010; K = 4'b0110;
    go("jk1", E(16'hA, 0, 0, 1, 0, 0, 1));
    J = 4'b1010; K = 4'b0110;
    go("jk2", E(16'h8, 0, 0, 1, 0, 0, 1));

    wr(4'b0101);
    go("wr5", E(16'h5, 0, 0, 1, 0, 0, 1));
    UPD = 1; UPD_MASK = 4'b1100; ALU_FLAGS = 4'b1000;
    J = 4'b0011; K = 4'b0011;
    go("upd_mask", E(16'hA, 0, 0, 1, 0, 0, 1));
    wr(4'b0101);
    go("wr5b", E(16'h5, 0, 0, 1, 0, 0, 1));
    UPD = 1; UPD_MASK = 4'b1100; ALU_FLAGS = 4'b1000;
    J = 4'b0011; K = 4'b0011; wr(4'b0001);
    go("wr_over_upd", E(16'h1, 0, 0, 1, 0, 0, 1));

    tbl = 16'h6996;
    sweep("cc1001", 4'b1001);
    tbl = 16'h6A69;
    sweep("cc0110", 4'b0110);
    tbl = 16'h56AA;
    sweep("cc0000", 4'b0000);

    wr(4'h1);
    go("fill_w1", E(16'h1, 0, 0, 1, 0, 0, 1));
    PUSH = 1; wr(4'h2);
    go("push1", E(16'h2, 1, 0, 0, 0, 0, 1));
    PUSH = 1; wr(4'h3);
    go("push2", E(16'h3, 2, 0, 0, 0, 0, 1));
    PUSH = 1; wr(4'h4);
    go("push3", E(16'h4, 3, 0, 0, 0, 0, 1));
    PUSH = 1;
    go("push4_full", E(16'h4, 4, 1, 0, 0, 0, 1));
    PUSH = 1; wr(4'h5);
    go("push5_ovf", E(16'h5, 4, 1, 0, 1, 0, 1));
    POP = 1;
    go("pop4", E(16'h4, 3, 0, 0, 1, 0, 1));
    POP = 1; wr(4'hF);
    go("pop3_over_wr", E(16'h3, 2, 0, 0, 1, 0, 1));
    POP = 1;
    go("pop2", E(16'h2, 1, 0, 0, 1, 0, 1));
    POP = 1; J = 4'hF;
    go("pop1_over_jk", E(16'h1, 0, 0, 1, 1, 0, 1));
    POP = 1;
    go("pop5_unf", E(16'h1, 0, 0, 1, 1, 1, 1));
    POP = 1; wr(4'h6);
    go("unf_wr", E(16'h6, 0, 0, 1, 1, 1, 1));

    CLR = 1; J = 4'hF; PUSH = 1; wr(4'hF);
    go("clr_sticky", E(16'h0, 0, 0, 1, 0, 0, 1));
    PUSH = 1; POP = 1; wr(4'h9);
    go("pushpop_empty", E(16'h9, 1, 0, 0, 0, 0, 1));
    wr(4'h7);
    go("w7", E(16'h7, 1, 0, 0, 0, 0, 1));
    PUSH = 1; wr(4'h9);
    go("push7", E(16'h9, 2, 0, 0, 0, 0, 1));
    PUSH = 1; POP = 1;
    go("swap", E(16'h7, 2, 0, 0, 0, 0, 1));
    POP = 1;
    go("pop_swapped", E(16'h9, 1, 0, 0, 0, 0, 1));
    POP = 1;
    go("pop_first", E(16'h0, 0, 0, 1, 0, 0, 1));

    wr(4'hA);
    go("wA", E(16'hA, 0, 0, 1, 0, 0, 1));
    PUSH = 1; wr(4'hB);
    go("fpush1", E(16'hB, 1, 0, 0, 0, 0, 1));
    PUSH = 1; wr(4'hC);
    go("fpush2", E(16'hC, 2, 0, 0, 0, 0, 1));
    PUSH = 1; wr(4'hD);
    go("fpush3", E(16'hD, 3, 0, 0, 0, 0, 1));
    PUSH = 1;
    go("fpush4", E(16'hD, 4, 1, 0, 0, 0, 1));
    wr(4'hE);
    go("wE_full", E(16'hE, 4, 1, 0, 0, 0, 1));
    PUSH = 1; POP = 1;
    go("swap_full", E(16'hD, 4, 1, 0, 0, 0, 1));
    PUSH = 1;
    go("ovf_full", E(16'hD, 4, 1, 0, 1, 0, 1));
    POP = 1;
    go("pop_after_ovf", E(16'hE, 3, 0, 0, 1, 0, 1));
    CLR = 1; PUSH = 1; wr(4'hF);
    go("clr_push", E(16'h0, 0, 0, 1, 0, 0, 1));
    POP = 1;
    go("pop_after_clr", E(16'h0, 0, 0, 1, 0, 1, 1));

    for (int i = 0; i < 4 && q_exp.size() > 0; i++) begin
      @(negedge CLK);
      #1;
    end
    if (q_exp.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", q_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
